// File: rtl/shifter_iter.sv
// Multi-cycle shifter: resolves one log2 stage of the shift amount per clock
// (SLL, SRL, SRA, ROL, ROR) behind a ready/start/done handshake.
module shifter_iter #(
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [2:0]               mode,
  output logic [WIDTH-1:0]         result,
  output logic                     ready,
  output logic                     done,
  output logic                     illegal
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] K_LAST = SHW'(SHW - 1);

  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                     state_reg, state_next;
  logic [WIDTH-1:0]           work_reg;
  logic [SHW-1:0]             shamt_reg;
  logic [2:0]                 mode_reg;
  logic                       sign_reg;
  logic [SHW-1:0]             k_reg;
  logic [WIDTH-1:0]           result_reg;
  logic                       illegal_reg;
  logic                       ready_reg;
  logic                       done_reg;

  logic                       mode_legal;
  logic [SHW-1:0][WIDTH-1:0]  stage_val;
  logic [WIDTH-1:0]           stage_sel;
  logic                       stage_en;
  logic [WIDTH-1:0]           work_next;

  assign mode_legal = (mode <= MODE_ROR);

  // Each stage gi shifts the work register by a fixed 2^gi; only the
  // stage selected by k is used in a given cycle.
  for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
    localparam int S = 1 << gi;
    assign stage_val[gi] =
      (mode_reg == MODE_SLL) ? {work_reg[WIDTH-1-S:0], {S{1'b0}}} :
      (mode_reg == MODE_SRL) ? {{S{1'b0}}, work_reg[WIDTH-1:S]} :
      (mode_reg == MODE_SRA) ? {{S{sign_reg}}, work_reg[WIDTH-1:S]} :
      (mode_reg == MODE_ROL) ? {work_reg[WIDTH-1-S:0], work_reg[WIDTH-1:WIDTH-S]} :
                               {work_reg[S-1:0], work_reg[WIDTH-1:S]};
  end

  always_comb begin
    stage_sel = work_reg;
    stage_en  = 1'b0;
    for (int i = 0; i < SHW; i++) begin
      if (k_reg == SHW'(i)) begin
        stage_sel = stage_val[i];
        stage_en  = shamt_reg[i];
      end
    end
  end

  assign work_next = stage_en ? stage_sel : work_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = mode_legal ? SHIFT : DONE;
      SHIFT:   if (k_reg == K_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      work_reg    <= '0;
      shamt_reg   <= '0;
      mode_reg    <= '0;
      sign_reg    <= 1'b0;
      k_reg       <= '0;
      result_reg  <= '0;
      illegal_reg <= 1'b0;
      ready_reg   <= 1'b1;
      done_reg    <= 1'b0;
    end else begin
      // Handshake flags track the next state so they come straight from flops.
      ready_reg <= (state_next == IDLE);
      done_reg  <= (state_next == DONE);
      case (state_reg)
        IDLE: begin
          if (start) begin
            work_reg  <= data_in;
            shamt_reg <= shamt;
            mode_reg  <= mode;
            sign_reg  <= data_in[WIDTH-1];
            k_reg     <= '0;
            if (!mode_legal) begin
              result_reg  <= data_in;
              illegal_reg <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work_reg <= work_next;
          k_reg    <= k_reg + 1'b1;
          if (k_reg == K_LAST) begin
            result_reg  <= work_next;
            illegal_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result  = result_reg;
  assign illegal = illegal_reg;
  assign ready   = ready_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_shifter_iter.sv
// Directed self-checking bench for shifter_iter at WIDTH=32 and WIDTH=8.
module tb_shifter_iter;
  logic        clock;
  logic        reset_n;

  logic        start32;
  logic [31:0] data32;
  logic [4:0]  shamt32;
  logic [2:0]  mode32;
  logic [31:0] res32;
  logic        rdy32, done32, ill32;

  logic        start8;
  logic [7:0]  data8;
  logic [2:0]  shamt8;
  logic [2:0]  mode8;
  logic [7:0]  res8;
  logic        rdy8, done8, ill8;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int last_e0  = 0;
  int done_cnt32 = 0;

  shifter_iter #(.WIDTH(32)) dut32 (
    .clock(clock), .reset_n(reset_n), .start(start32), .data_in(data32),
    .shamt(shamt32), .mode(mode32), .result(res32), .ready(rdy32),
    .done(done32), .illegal(ill32)
  );

  shifter_iter #(.WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .start(start8), .data_in(data8),
    .shamt(shamt8), .mode(mode8), .result(res8), .ready(rdy8),
    .done(done8), .illegal(ill8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;
  always @(negedge clock) if (done32 === 1'b1) done_cnt32++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the target DUT idle; returns at the negedge
  // after the done cycle, so consecutive calls issue back-to-back starts.
  task automatic do_op(input bit w8, input logic [31:0] d, input logic [4:0] s,
                       input logic [2:0] m, input logic [31:0] exp,
                       input logic exp_ill, input string tag);
    int n;
    int lat;
    lat = (m > 3'd4) ? 1 : (w8 ? 4 : 6);
    check({tag, " ready before"}, 32'(w8 ? rdy8 : rdy32), 32'd1);
    if (w8) begin
      start8 = 1'b1; data8 = d[7:0]; shamt8 = s[2:0]; mode8 = m;
    end else begin
      start32 = 1'b1; data32 = d; shamt32 = s; mode32 = m;
    end
    last_e0 = cyc + 1;
    @(negedge clock);
    start8 = 1'b0; start32 = 1'b0;
    data32 = ~d; data8 = ~d[7:0]; shamt32 = ~s; shamt8 = ~s[2:0];
    mode32 = 3'b111; mode8 = 3'b111;
    n = 1;
    while (!(w8 ? done8 : done32) && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({tag, " done"}, 32'(w8 ? done8 : done32), 32'd1);
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " result"}, w8 ? 32'(res8) : res32, exp);
    check({tag, " illegal"}, 32'(w8 ? ill8 : ill32), 32'(exp_ill));
    check({tag, " ready in done"}, 32'(w8 ? rdy8 : rdy32), 32'd0);
    @(negedge clock);
    check({tag, " done cleared"}, 32'(w8 ? done8 : done32), 32'd0);
    check({tag, " ready back"}, 32'(w8 ? rdy8 : rdy32), 32'd1);
  endtask

  initial begin
    int p;
    int dc;
    int n;
    reset_n = 1'b0;
    start32 = 1'b0; data32 = '0; shamt32 = '0; mode32 = '0;
    start8  = 1'b0; data8  = '0; shamt8  = '0; mode8  = '0;
    repeat (3) @(negedge clock);
    check("reset result32", res32, 32'h0);
    check("reset ready32", 32'(rdy32), 32'd1);
    check("reset done32", 32'(done32), 32'd0);
    check("reset illegal32", 32'(ill32), 32'd0);
    check("reset result8", 32'(res8), 32'h0);
    check("reset ready8", 32'(rdy8), 32'd1);
    reset_n = 1'b1;
    @(negedge clock);

    do_op(0, 32'h8000_0000, 5'd4,  3'b010, 32'hF800_0000, 1'b0, "sra 80000000>>4");
    do_op(0, 32'h8000_0000, 5'd4,  3'b001, 32'h0800_0000, 1'b0, "srl 80000000>>4");
    do_op(0, 32'h0000_0001, 5'd31, 3'b000, 32'h8000_0000, 1'b0, "sll 1<<31");
    do_op(0, 32'h0000_00FF, 5'd12, 3'b000, 32'h000F_F000, 1'b0, "sll ff<<12");
    do_op(0, 32'h8000_0001, 5'd1,  3'b011, 32'h0000_0003, 1'b0, "rol 80000001 1");
    do_op(0, 32'h0000_0003, 5'd1,  3'b100, 32'h8000_0001, 1'b0, "ror 3 1");
    do_op(0, 32'h1234_5678, 5'd16, 3'b100, 32'h5678_1234, 1'b0, "ror 12345678 16");
    do_op(0, 32'h1234_5678, 5'd8,  3'b011, 32'h3456_7812, 1'b0, "rol 12345678 8");
    do_op(0, 32'h7FFF_FFFF, 5'd31, 3'b010, 32'h0000_0000, 1'b0, "sra 7fffffff 31");
    do_op(0, 32'hFFFF_FFFF, 5'd31, 3'b010, 32'hFFFF_FFFF, 1'b0, "sra ffffffff 31");

    do_op(0, 32'h9ABC_DEF1, 5'd0, 3'b000, 32'h9ABC_DEF1, 1'b0, "sll by 0");
    do_op(0, 32'h9ABC_DEF1, 5'd0, 3'b001, 32'h9ABC_DEF1, 1'b0, "srl by 0");
    do_op(0, 32'h9ABC_DEF1, 5'd0, 3'b010, 32'h9ABC_DEF1, 1'b0, "sra by 0");
    do_op(0, 32'h9ABC_DEF1, 5'd0, 3'b011, 32'h9ABC_DEF1, 1'b0, "rol by 0");
    do_op(0, 32'h9ABC_DEF1, 5'd0, 3'b100, 32'h9ABC_DEF1, 1'b0, "ror by 0");

    do_op(0, 32'hDEAD_BEEF, 5'd3, 3'b111, 32'hDEAD_BEEF, 1'b1, "illegal 111");
    do_op(0, 32'h0000_00F0, 5'd4, 3'b001, 32'h0000_000F, 1'b0, "legal after illegal");

    p = last_e0;
    do_op(0, 32'h0000_0010, 5'd1, 3'b001, 32'h0000_0008, 1'b0, "b2b op1");
    check("b2b spacing 1", 32'(last_e0 - p), 32'd7);
    p = last_e0;
    do_op(0, 32'h0000_0010, 5'd2, 3'b000, 32'h0000_0040, 1'b0, "b2b op2");
    check("b2b spacing 2", 32'(last_e0 - p), 32'd7);

    // Extra starts during SHIFT and during DONE must be dropped.
    dc = done_cnt32;
    start32 = 1'b1; data32 = 32'h0000_0100; shamt32 = 5'd8; mode32 = 3'b001;
    @(negedge clock);
    start32 = 1'b0;
    @(negedge clock);
    start32 = 1'b1; data32 = 32'hFFFF_FFFF; shamt32 = 5'd1; mode32 = 3'b000;
    @(negedge clock);
    start32 = 1'b0;
    n = 0;
    while (!done32 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("ignore done seen", 32'(done32), 32'd1);
    start32 = 1'b1;
    @(negedge clock);
    start32 = 1'b0;
    repeat (10) @(negedge clock);
    check("ignore done count", 32'(done_cnt32 - dc), 32'd1);
    check("ignore result", res32, 32'h0000_0001);
    check("ignore ready idle", 32'(rdy32), 32'd1);

    // Reset two cycles into an operation discards it.
    dc = done_cnt32;
    start32 = 1'b1; data32 = 32'h0000_000F; shamt32 = 5'd4; mode32 = 3'b000;
    @(negedge clock);
    start32 = 1'b0;
    @(negedge clock);
    check("pre-reset busy", 32'(rdy32), 32'd0);
    reset_n = 1'b0;
    #1;
    check("mid reset result", res32, 32'h0);
    check("mid reset ready", 32'(rdy32), 32'd1);
    check("mid reset done", 32'(done32), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    check("no done after reset", 32'(done_cnt32 - dc), 32'd0);
    check("result held at 0", res32, 32'h0);
    do_op(0, 32'h0000_000F, 5'd4, 3'b000, 32'h0000_00F0, 1'b0, "op after reset");

    do_op(1, 32'h0000_0090, 5'd3, 3'b010, 32'h0000_00F2, 1'b0, "w8 sra 90 3");
    do_op(1, 32'h0000_0081, 5'd7, 3'b011, 32'h0000_00C0, 1'b0, "w8 rol 81 7");
    do_op(1, 32'h0000_0081, 5'd1, 3'b100, 32'h0000_00C0, 1'b0, "w8 ror 81 1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
